// File: rtl/lut_eval_pipe.sv
// K-input truth-table evaluator: CH programmable channels, a registered
// valid/ready lookup path and an exhaustive sweep scorer.
module lut_eval_pipe #(
    parameter int K = 4,
    parameter int CH = 2,
    parameter int T = 2 ** K,
    parameter int CW = (CH > 1) ? $clog2(CH) : 1,
    parameter logic [T-1:0] INIT = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_ch,
    input  logic [T-1:0]  cfg_table,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_ch,
    input  logic [K-1:0]  in_vec,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_ch,
    output logic          out_bit,
    input  logic          sweep_start,
    input  logic [CW-1:0] sweep_ch,
    input  logic [T-1:0]  sweep_target,
    output logic          sweep_busy,
    output logic          sweep_done,
    output logic [K:0]    sweep_score
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    logic [T-1:0] tbl [CH];
    logic [T-1:0] eval_row;
    logic [T-1:0] sweep_row;
    logic [T-1:0] snap;
    logic [T-1:0] tgt;
    logic [K-1:0] idx;
    logic [K:0]   acc;
    logic         match;
    state_t       state;

    // Out-of-range channels read as an all-zero table.
    always_comb begin
        eval_row  = '0;
        sweep_row = '0;
        for (int i = 0; i < CH; i++) begin
            if (int'(in_ch) == i)
                eval_row = tbl[i];
            if (int'(sweep_ch) == i)
                sweep_row = tbl[i];
        end
    end

    assign match    = (snap[idx] == tgt[idx]);
    assign in_ready = !sweep_busy && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (rst)
                tbl[i] <= INIT;
            else if (cfg_we && int'(cfg_ch) == i)
                tbl[i] <= cfg_table;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_bit   <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            out_bit   <= eval_row[in_vec];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            snap        <= '0;
            tgt         <= '0;
            idx         <= '0;
            acc         <= '0;
            sweep_busy  <= 1'b0;
            sweep_done  <= 1'b0;
            sweep_score <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    sweep_done <= 1'b0;
                    if (sweep_start) begin
                        snap       <= sweep_row;
                        tgt        <= sweep_target;
                        idx        <= '0;
                        acc        <= '0;
                        sweep_busy <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc + {{K{1'b0}}, match};
                    idx <= idx + 1'b1;
                    // Score lands with the done pulse in the following cycle.
                    if (idx == K'(T - 1)) begin
                        sweep_score <= acc + {{K{1'b0}}, match};
                        sweep_done  <= 1'b1;
                        sweep_busy  <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    sweep_done <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_eval_pipe.sv
// Directed bench for lut_eval_pipe (K=4, CH=2, INIT=0): lookup,
// backpressure, write collision, sweep scoring and reset abort.
module tb_lut_eval_pipe;

    localparam int K = 4;
    localparam int CH = 2;
    localparam int T = 16;
    localparam int CW = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [CW-1:0] cfg_ch = '0;
    logic [T-1:0]  cfg_table = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ch = '0;
    logic [K-1:0]  in_vec = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_ch;
    logic          out_bit;
    logic          sweep_start = 1'b0;
    logic [CW-1:0] sweep_ch = '0;
    logic [T-1:0]  sweep_target = '0;
    logic          sweep_busy;
    logic          sweep_done;
    logic [K:0]    sweep_score;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lut_eval_pipe #(.K(K), .CH(CH), .INIT('0)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_table(cfg_table),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_bit(out_bit),
        .sweep_start(sweep_start), .sweep_ch(sweep_ch),
        .sweep_target(sweep_target), .sweep_busy(sweep_busy),
        .sweep_done(sweep_done), .sweep_score(sweep_score)
    );

    task automatic write_cfg(input logic ch, input logic [T-1:0] tb);
        cfg_we = 1'b1; cfg_ch = ch; cfg_table = tb;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic eval_one(input logic ch, input logic [K-1:0] v,
                            output logic ov, output logic oc,
                            output logic ob);
        in_valid = 1'b1; in_ch = ch; in_vec = v; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        ov = out_valid; oc = out_ch; ob = out_bit;
    endtask

    task automatic test_reset;
        logic ov, oc, ob;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({out_valid, sweep_busy, sweep_done} !== 3'b000 ||
            sweep_score !== 5'd0) begin
            n_err++;
            $display("FAIL reset: ov/busy/done=%b score=%0d want 000/0",
                     {out_valid, sweep_busy, sweep_done}, sweep_score);
        end
        eval_one(1'b0, 4'b1111, ov, oc, ob);
        n_vec++;
        if (ov !== 1'b1 || ob !== 1'b0) begin
            n_err++;
            $display("FAIL reset_eval0: ov=%b bit=%b want 1/0", ov, ob);
        end
        eval_one(1'b1, 4'b0000, ov, oc, ob);
        n_vec++;
        if (ov !== 1'b1 || ob !== 1'b0) begin
            n_err++;
            $display("FAIL reset_eval1: ov=%b bit=%b want 1/0", ov, ob);
        end
    endtask

    task automatic test_lookup;
        logic ov, oc, ob;
        logic       vch [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] vv  [4] = '{4'b1111, 4'b0001, 4'b0000, 4'b1101};
        logic       vex [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        write_cfg(1'b0, 16'hC000);
        write_cfg(1'b1, 16'h0001);
        eval_one(1'b0, 4'b1110, ov, oc, ob);
        n_vec++;
        if ({ov, oc, ob} !== 3'b101) begin
            n_err++;
            $display("FAIL lookup_1110: v/ch/bit=%b want 101", {ov, oc, ob});
        end
        eval_one(1'b0, 4'b0100, ov, oc, ob);
        n_vec++;
        if ({ov, oc, ob} !== 3'b100) begin
            n_err++;
            $display("FAIL lookup_0100: v/ch/bit=%b want 100", {ov, oc, ob});
        end
        eval_one(1'b1, 4'b0000, ov, oc, ob);
        n_vec++;
        if ({ov, oc, ob} !== 3'b111) begin
            n_err++;
            $display("FAIL lookup_ch1: v/ch/bit=%b want 111", {ov, oc, ob});
        end
        // back-to-back stream
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_ch = vch[i]; in_vec = vv[i];
            @(negedge clk);
            n_vec++;
            if ({out_valid, out_ch, out_bit} !== {1'b1, vch[i], vex[i]}) begin
                n_err++;
                $display("FAIL b2b[%0d]: v/ch/bit=%b want %b", i,
                         {out_valid, out_ch, out_bit}, {1'b1, vch[i], vex[i]});
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        in_valid = 1'b1; in_ch = 1'b0; in_vec = 4'b1110; out_ready = 1'b1;
        @(negedge clk);
        in_ch = 1'b1; in_vec = 4'b0001; out_ready = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_ready: in_ready=%b want 0", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({out_valid, out_ch, out_bit, in_ready} !== 4'b1010) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: v/ch/bit/rdy=%b want 1010", i,
                         {out_valid, out_ch, out_bit, in_ready});
            end
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: in_ready=%b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if ({out_valid, out_ch, out_bit} !== 3'b110) begin
            n_err++;
            $display("FAIL bp_next: v/ch/bit=%b want 110",
                     {out_valid, out_ch, out_bit});
        end
        @(negedge clk);
    endtask

    task automatic test_collision;
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_table = 16'h0000;
        in_valid = 1'b1; in_ch = 1'b0; in_vec = 4'b1111; out_ready = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        n_vec++;
        if (out_bit !== 1'b1) begin
            n_err++;
            $display("FAIL coll_old: bit=%b want 1", out_bit);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (out_bit !== 1'b0) begin
            n_err++;
            $display("FAIL coll_new: bit=%b want 0", out_bit);
        end
        @(negedge clk);
        write_cfg(1'b0, 16'hC000);
    endtask

    task automatic test_sweep(input logic [T-1:0] target, input int exp_score,
                              input logic also_write);
        sweep_start = 1'b1; sweep_ch = 1'b0; sweep_target = target;
        if (also_write) begin
            cfg_we = 1'b1; cfg_ch = 1'b0; cfg_table = 16'hFFFF;
        end
        @(negedge clk);
        sweep_start = 1'b0; cfg_we = 1'b0;
        in_valid = 1'b1; in_ch = 1'b0; in_vec = '0; out_ready = 1'b1;
        for (int c = 1; c <= T; c++) begin
            n_vec++;
            if ({sweep_busy, in_ready, sweep_done} !== 3'b100) begin
                n_err++;
                $display("FAIL sweep_run c%0d: busy/rdy/done=%b want 100", c,
                         {sweep_busy, in_ready, sweep_done});
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_vec++;
        if (sweep_done !== 1'b1 || sweep_busy !== 1'b0 ||
            int'(sweep_score) != exp_score) begin
            n_err++;
            $display("FAIL sweep_done %h: done=%b busy=%b score=%0d want 1/0/%0d",
                     target, sweep_done, sweep_busy, sweep_score, exp_score);
        end
        @(negedge clk);
        n_vec++;
        if (sweep_done !== 1'b0 || int'(sweep_score) != exp_score) begin
            n_err++;
            $display("FAIL sweep_hold: done=%b score=%0d want 0/%0d",
                     sweep_done, sweep_score, exp_score);
        end
        if (also_write)
            write_cfg(1'b0, 16'hC000);
    endtask

    task automatic test_abort;
        logic ov, oc, ob;
        int seen;
        sweep_start = 1'b1; sweep_ch = 1'b0; sweep_target = 16'hC000;
        @(negedge clk);
        sweep_start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (sweep_busy !== 1'b0 || sweep_done !== 1'b0 ||
            sweep_score !== 5'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort: busy=%b done=%b score=%0d ov=%b want 0/0/0/0",
                     sweep_busy, sweep_done, sweep_score, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sweep_done === 1'b1) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL abort_nodone: pulses=%0d want 0", seen);
        end
        eval_one(1'b0, 4'b1111, ov, oc, ob);
        n_vec++;
        if (ob !== 1'b0) begin
            n_err++;
            $display("FAIL abort_init: bit=%b want 0", ob);
        end
        test_sweep(16'h0003, 14, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_lookup;
        test_backpressure;
        test_collision;
        test_sweep(16'hC000, 16, 1'b0);
        test_sweep(16'h3FFF, 0, 1'b0);
        test_sweep(16'h8000, 15, 1'b0);
        test_sweep(16'hC000, 16, 1'b1);
        test_abort;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lut_eval_pipe.md
# lut_eval_pipe

Parametrised, registered K-input truth-table evaluator holding CH independently programmable logic functions. It is the successor to the fixed 4-input combinational function blocks. It serves the evaluation datapath in two ways:
- per-vector evaluation through a valid/ready pipeline;
- an exhaustive sweep engine that scores a stored function against a target truth table, for fitness evaluation.

## Interface

Parameters:
- K, 4, number of function inputs (2..6); table width T = 2^K.
- CH, 2, number of function channels (1..8); CW = max(1, clog2(CH)).
- INIT, {T{1'b0}}, reset value loaded into every channel table.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_we  input  1  table write strobe.
- cfg_ch  input  CW  channel to write.
- cfg_table  input  T  new truth table; bit i = f(index i).
- in_valid  input  1  evaluation request valid.
- in_ready  output  1  evaluation request accepted when high with in_valid.
- in_ch  input  CW  channel to evaluate.
- in_vec  input  K  input vector; MSB is first operand (a), LSB last.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_ch  output  CW  channel of result.
- out_bit  output  1  f(in_vec).
- sweep_start  input  1  start exhaustive scoring.
- sweep_ch  input  CW  channel to score.
- sweep_target  input  T  target truth table.
- sweep_busy  output  1  sweep in progress.
- sweep_done  output  1  one-cycle pulse, score valid.
- sweep_score  output  K+1  count of indices where table and target agree (0..T).

## Operation

- Reset is synchronous and active-high.
- Reset state:
  - all tables = INIT;
  - out_valid = 0, out_ch = 0, out_bit = 0;
  - sweep FSM in IDLE, sweep_busy = 0, sweep_done = 0, sweep_score = 0.
- Table lookup: out_bit = table[in_ch][in_vec], with in_vec taken as an unsigned index. Example, K=4: table 16'hC000 gives 1 only for 1110 and 1111.
- Config write:
  - cfg_we writes cfg_table into table[cfg_ch] at the clock edge.
  - An evaluation or sweep snapshot taken in the same cycle uses the old table.
  - cfg_ch >= CH is ignored.
- Eval pipeline: single output register.
  - in_ready = !sweep_busy && (!out_valid || out_ready).
  - Transfer occurs when in_valid && in_ready.
  - out_valid and its payload hold stable while out_valid && !out_ready.
  - in_ch >= CH returns out_bit = 0.
- Sweep FSM states:
  - IDLE: sweep_start is accepted. The FSM latches snap = table[sweep_ch] (old value if written the same cycle) and tgt = sweep_target, clears idx and acc, then goes to RUN. The pending eval output may still drain.
  - RUN: each cycle, acc += (snap[idx] == tgt[idx]) and idx++. After idx = T-1 is processed the FSM goes to DONE. Config writes do not affect snap.
  - DONE: sweep_score <= acc, sweep_done = 1 for exactly one cycle, then the FSM returns to IDLE.
- sweep_start outside IDLE is ignored.
- sweep_score holds until the next DONE.
- acc is K+1 bits wide and never wraps; the maximum value T is representable.
- sweep_ch >= CH scores a table of all zeros.

## Timing

- Eval latency: a request accepted at edge n gives out_valid high after edge n, i.e. in cycle n+1.
- Throughput: 1 per cycle while out_ready = 1.
- Sweep timing, with sweep_start accepted in cycle t:
  - sweep_busy high in cycles t+1 .. t+T;
  - sweep_done high in cycle t+T+1, with sweep_score valid in the same cycle.
  - Total 2^K + 1 cycles from start to done.
- in_ready is low in every cycle where sweep_busy is high. A pending out_valid still completes on out_ready.
- Reset mid-operation:
  - sweep aborts to IDLE with no done pulse and sweep_score = 0;
  - the pending output is discarded (out_valid = 0);
  - tables return to INIT.
- Simultaneous cfg_we and sweep_start on the same channel: the snapshot uses the pre-write table; the new table is visible from the next cycle.

## Test plan

- Reset: assert rst 2 cycles with INIT=0 -> out_valid=0, sweep_busy=0, sweep_done=0, sweep_score=0; evaluating any vector returns 0.
- Lookup: write ch0=16'hC000, ch1=16'h0001. Then:
  - in_vec 4'b1110 on ch0 -> out_bit=1 one cycle later;
  - 4'b0100 on ch0 -> 0;
  - 4'b0000 on ch1 -> 1.
  - Back-to-back requests produce back-to-back results.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, and out_bit/out_ch stay stable; release -> next request transfers the same cycle.
- Write/eval collision: ch0=16'hC000, then in the same cycle cfg_we writes ch0=16'h0000 and a request evaluates ch0 with 4'b1111 -> out_bit=1; the next request with the same vector returns 0.
- Sweep: ch0=16'hC000.
  - target 16'hC000 -> sweep_done at t+17, score 16;
  - target 16'h3FFF -> score 0;
  - target 16'h8000 -> score 15;
  - in_ready=0 throughout sweep_busy.
- Abort: assert rst at RUN cycle 5 -> no sweep_done, sweep_score=0, tables=INIT; a subsequent sweep completes normally.
